imem_load_ctrl: RTL and testbench
=================================

Name: imem_load_ctrl

Overview:
- Sequencer that loads the instruction memory from the UART byte stream and arbitrates memory access between the loader and CPU fetch.
- Accepts a framed image: length byte, then N big-endian 32-bit words, then an XOR checksum byte.
- Issues one-cycle word writes into the IMEM write port and stalls the CPU while a load is in progress or has failed.
- Sits between uart_rx, the IMEM array and the CPU fetch stage.

Parameters:
- ADDR_W, 8, IMEM word-address width (depth 2^ADDR_W).
- TIMEOUT_CYCLES, 500000, maximum idle cycles allowed between bytes of a frame (10 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  permits start to be accepted.
- start  in  1  one-cycle pulse that begins or restarts a load.
- rx_valid  in  1  one-cycle pulse from uart_rx marking a new byte.
- rx_data  in  8  received byte, valid when rx_valid=1.
- cpu_addr  in  ADDR_W  CPU fetch address.
- mem_raddr  out  ADDR_W  IMEM read address; always equals cpu_addr (combinational).
- mem_we  out  1  IMEM write strobe, high for exactly one cycle per word.
- mem_waddr  out  ADDR_W  IMEM write address.
- mem_wdata  out  32  assembled word; byte0 goes to [31:24], byte3 to [7:0].
- cpu_stall  out  1  holds the CPU fetch stage.
- busy  out  1  load in progress.
- load_done  out  1  last load completed and its checksum matched.
- timeout_err  out  1  last load aborted by the inter-byte timeout.
- chk_err  out  1  last load failed the checksum compare.
- word_count  out  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- States: IDLE, LEN, B0, B1, B2, B3, WRITE, CHK, DONE, ERR.
- Reset values: state=IDLE; all outputs 0 except mem_raddr. Reset overrides every other input.
- start && load_en in any state moves to LEN and clears pointer, word_count, checksum accumulator, flags and timer. A restart mid-load discards any partial word; words already written stay in the IMEM.
- rx_valid is ignored in IDLE, DONE and ERR.
- LEN: on rx_valid, latch N = rx_data, with 0 meaning 2^ADDR_W words. Then go to B0.
- B0 to B3: on rx_valid, store the byte into the matching lane of the word register and advance. B3 goes to WRITE.
- WRITE: lasts exactly one cycle.
  - mem_we=1, mem_waddr=pointer, mem_wdata=assembled word.
  - Next cycle: pointer+1 and word_count+1.
  - Then go to CHK if word_count+1 equals N, otherwise B0.
  - A rx_valid during WRITE is taken as the first byte of the next state (B0 lane or checksum byte).
- Pointer wraps modulo 2^ADDR_W. N=0 writes addresses 0..2^ADDR_W-1 with no overflow.
- Checksum: XOR of the length byte and all payload bytes.
- CHK: on rx_valid, compare the byte against the accumulator. Match goes to DONE with load_done=1; mismatch goes to ERR with chk_err=1.
- Timer:
  - Cleared on entering LEN and on every accepted byte.
  - Counts up in LEN, B0-B3, WRITE and CHK.
  - Reaching TIMEOUT_CYCLES goes to ERR with timeout_err=1.
  - A timeout and a rx_valid in the same cycle: the byte wins.
- Flags (load_done, timeout_err, chk_err) and word_count hold until the next accepted start or reset.
- busy=1 in LEN through CHK.
- cpu_stall=1 in LEN through CHK and in ERR; 0 in IDLE and DONE.
- mem_we=0 outside WRITE.

Decomposition:
- Package imem_load_pkg holds:
  - the state enum;
  - the byte-lane constants (lane 0 = [31:24]);
  - the N=0 → full-depth rule as a function of ADDR_W.
- Sub-module imem_load_timer: clear/enable inputs, expired output, width $clog2(TIMEOUT_CYCLES+1).
- The FSM, byte assembly and checksum live in imem_load_ctrl.

Test Plan (bench uses TIMEOUT_CYCLES=100):
- Normal load, 2 words:
  - Stimulus: start, then bytes 02 DE AD BE EF 01 23 45 67 and checksum 0x02^0xDE^...^0x67.
  - Required: writes 0xDEADBEEF@0 and 0x01234567@1; word_count=2; load_done=1; cpu_stall falls one cycle after the checksum byte.
- Checksum mismatch:
  - Stimulus: same frame with a checksum byte of (correct ^ 0x01).
  - Required: chk_err=1, cpu_stall stays 1, load_done=0.
- Timeout:
  - Stimulus: send 01 AA BB, then silence for 100 cycles.
  - Required: timeout_err=1, mem_we never asserted, word_count=0.
- Restart mid-word:
  - Stimulus: send 01 11 22, pulse start, then send 01 CA FE BA BE plus a valid checksum.
  - Required: single write of 0xCAFEBABE@0, load_done=1.
- Full depth:
  - Stimulus: N=00 with 256 words whose value equals their index.
  - Required: addresses 0..255 written in order; word_count=256; pointer wraps to 0; load_done=1.
- Edge cases:
  - start with load_en=0 → ignored.
  - reset asserted during B2 → all outputs 0 next cycle.
  - rx_valid in IDLE → no write.

Source files
------------

// File: rtl/imem_load_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package imem_load_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEN,
    B0,
    B1,
    B2,
    B3,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_t;

  // Byte lanes of the assembled word; the first payload byte is the most significant.
  localparam int LANE0_LSB = 24;
  localparam int LANE1_LSB = 16;
  localparam int LANE2_LSB = 8;
  localparam int LANE3_LSB = 0;

  // A length byte of zero stands for a full memory image of 2^addr_w words.
  function automatic int unsigned frame_words(input logic [7:0] len_byte, input int addr_w);
    if (len_byte == 8'd0) begin
      return 32'd1 << addr_w;
    end
    return {24'd0, len_byte};
  endfunction

endpackage

// File: rtl/imem_load_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and saturates at the limit.
module imem_load_timer #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  // Count idle cycles while a frame is open; hold at the limit so expired stays asserted.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/imem_load_ctrl.sv
// Loads the instruction memory from a framed UART byte stream and stalls CPU fetch meanwhile.
// Frame: length byte, N big-endian 32-bit words, XOR checksum byte.
import imem_load_pkg::*;

module imem_load_ctrl #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              load_en,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_stall,
  output logic              busy,
  output logic              load_done,
  output logic              timeout_err,
  output logic              chk_err,
  output logic [ADDR_W:0]   word_count
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   target;
  logic [7:0]        chk_acc;
  logic [31:0]       word_reg;

  logic            start_acc;
  logic            byte_acc;
  logic            tmr_clear;
  logic            tmr_expired;
  logic            timed_out;
  logic            at_chk;
  logic            chk_ok;
  logic [ADDR_W:0] wc_next;
  logic [7:0]      chk_next;

  assign mem_raddr = cpu_addr;
  assign start_acc = start && load_en;
  assign byte_acc  = rx_valid && busy;
  assign tmr_clear = start_acc || byte_acc;
  assign timed_out = busy && tmr_expired && !rx_valid;
  assign wc_next   = word_count + 1'b1;
  assign chk_next  = chk_acc ^ rx_data;
  assign chk_ok    = (rx_data == chk_acc);
  // The checksum byte may already arrive in the write cycle of the last word.
  assign at_chk    = (state == CHK) || ((state == WRITE) && (wc_next == target));

  imem_load_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (CLOCK_50),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (busy),
    .expired(tmr_expired)
  );

  // Frame sequencer: length, byte lanes, word write, checksum, with registered status outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      target      <= '0;
      chk_acc     <= '0;
      word_reg    <= '0;
      mem_we      <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      cpu_stall   <= 1'b0;
      load_done   <= 1'b0;
      timeout_err <= 1'b0;
      chk_err     <= 1'b0;
      word_count  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_acc) begin
        state       <= LEN;
        ptr         <= '0;
        word_count  <= '0;
        chk_acc     <= '0;
        load_done   <= 1'b0;
        timeout_err <= 1'b0;
        chk_err     <= 1'b0;
        busy        <= 1'b1;
        cpu_stall   <= 1'b1;
      end else begin
        if (state == WRITE) begin
          ptr        <= ptr + 1'b1;
          word_count <= wc_next;
        end
        if (timed_out) begin
          state       <= ERR;
          timeout_err <= 1'b1;
          busy        <= 1'b0;
        end else if (rx_valid && at_chk) begin
          busy <= 1'b0;
          if (chk_ok) begin
            state     <= DONE;
            load_done <= 1'b1;
            cpu_stall <= 1'b0;
          end else begin
            state   <= ERR;
            chk_err <= 1'b1;
          end
        end else begin
          case (state)
            LEN: if (rx_valid) begin
              target  <= (ADDR_W + 1)'(frame_words(rx_data, ADDR_W));
              chk_acc <= chk_next;
              state   <= B0;
            end
            B0: if (rx_valid) begin
              word_reg[LANE0_LSB +: 8] <= rx_data;
              chk_acc                  <= chk_next;
              state                    <= B1;
            end
            B1: if (rx_valid) begin
              word_reg[LANE1_LSB +: 8] <= rx_data;
              chk_acc                  <= chk_next;
              state                    <= B2;
            end
            B2: if (rx_valid) begin
              word_reg[LANE2_LSB +: 8] <= rx_data;
              chk_acc                  <= chk_next;
              state                    <= B3;
            end
            B3: if (rx_valid) begin
              chk_acc                   <= chk_next;
              mem_we                    <= 1'b1;
              mem_waddr                 <= ptr;
              mem_wdata                 <= word_reg;
              mem_wdata[LANE3_LSB +: 8] <= rx_data;
              state                     <= WRITE;
            end
            WRITE: begin
              if (wc_next == target) begin
                state <= CHK;
              end else if (rx_valid) begin
                word_reg[LANE0_LSB +: 8] <= rx_data;
                chk_acc                  <= chk_next;
                state                    <= B1;
              end else begin
                state <= B0;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: frame-level reference model plus directed literal checks.
module tb_imem_load_ctrl;

  localparam int ADDR_W = 8;
  localparam int T      = 100;
  localparam int DEPTH  = 256;

  logic              CLOCK_50 = 1'b0;
  logic              reset;
  logic              load_en;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] cpu_addr;
  logic [ADDR_W-1:0] mem_raddr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_stall;
  logic              busy;
  logic              load_done;
  logic              timeout_err;
  logic              chk_err;
  logic [ADDR_W:0]   word_count;

  imem_load_ctrl #(
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .load_en    (load_en),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .cpu_addr   (cpu_addr),
    .mem_raddr  (mem_raddr),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_stall  (cpu_stall),
    .busy       (busy),
    .load_done  (load_done),
    .timeout_err(timeout_err),
    .chk_err    (chk_err),
    .word_count (word_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  logic [7:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [7:0]  frame_q[$];

  // Reference model: tracks a frame as a count of bytes received, not as the DUT's states.
  bit          m_active = 0, m_done = 0, m_terr = 0, m_cerr = 0, m_stall = 0, m_we = 0, nxt_we;
  int          m_k = 0, m_n = 0, m_wc = 0, m_idle = 0, m_waddr = 0;
  logic [7:0]  m_sum = 0;
  logic [31:0] m_word = 0, m_wdata = 0;

  always @(posedge CLOCK_50) begin
    if (reset) begin
      m_active = 0; m_done = 0; m_terr = 0; m_cerr = 0; m_stall = 0; m_wc = 0; m_we = 0;
    end else begin
      nxt_we = 0;
      if (start && load_en) begin
        m_active = 1; m_stall = 1; m_done = 0; m_terr = 0; m_cerr = 0;
        m_wc = 0; m_k = 0; m_sum = 0; m_idle = 0;
      end else if (m_active) begin
        if (m_we) m_wc++;
        if (rx_valid) begin
          m_idle = 0;
          if (m_k == 0) begin
            m_n = (rx_data == 8'd0) ? DEPTH : int'(rx_data);
            m_sum ^= rx_data;
            m_k = 1;
          end else if (m_k <= 4 * m_n) begin
            m_sum ^= rx_data;
            m_word = {m_word[23:0], rx_data};
            if (m_k % 4 == 0) begin
              nxt_we  = 1;
              m_waddr = m_wc % DEPTH;
              m_wdata = m_word;
            end
            m_k++;
          end else begin
            m_active = 0;
            if (rx_data == m_sum) begin
              m_done = 1; m_stall = 0;
            end else begin
              m_cerr = 1;
            end
          end
        end else if (m_idle == T) begin
          m_active = 0; m_terr = 1;
        end else begin
          m_idle++;
        end
      end
      m_we = nxt_we;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model, plus the write log.
  task automatic checkCycle();
    checkOutput("mem_raddr", 64'(mem_raddr), 64'(cpu_addr));
    checkOutput("mem_we", 64'(mem_we), 64'(m_we));
    if (m_we) begin
      checkOutput("mem_waddr", 64'(mem_waddr), 64'(m_waddr));
      checkOutput("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    checkOutput("busy", 64'(busy), 64'(m_active));
    checkOutput("cpu_stall", 64'(cpu_stall), 64'(m_stall));
    checkOutput("load_done", 64'(load_done), 64'(m_done));
    checkOutput("timeout_err", 64'(timeout_err), 64'(m_terr));
    checkOutput("chk_err", 64'(chk_err), 64'(m_cerr));
    checkOutput("word_count", 64'(word_count), 64'(m_wc));
    if (mem_we === 1'b1) begin
      log_addr.push_back(mem_waddr);
      log_data.push_back(mem_wdata);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
    if (check_en) checkCycle();
    @(posedge CLOCK_50);
    #2;
    cpu_addr = ADDR_W'($urandom);
  endtask

  task automatic pulseStart(input bit en);
    load_en = en;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) tick();
  endtask

  function automatic int pickGap(input bit allow_long);
    if (allow_long && ($urandom_range(0, 29) == 0)) return T + int'($urandom_range(0, 1));
    return int'($urandom_range(0, 3));
  endfunction

  // Sends frame_q followed by its XOR checksum (optionally corrupted) with random gaps.
  task automatic applyStimulus(input bit corrupt, input bit allow_long);
    logic [7:0] sum;
    sum = 8'd0;
    foreach (frame_q[i]) begin
      sum ^= frame_q[i];
      sendByte(frame_q[i], pickGap(allow_long));
    end
    sendByte(corrupt ? (sum ^ 8'h01) : sum, 0);
  endtask

  task automatic clearLog();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; cpu_addr = '0;
    tick();
    check_en = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("reset_busy", 64'(busy), 0);
    checkOutput("reset_stall", 64'(cpu_stall), 0);
    checkOutput("reset_wc", 64'(word_count), 0);
    checkOutput("reset_we", 64'(mem_we), 0);

    // Normal two-word load with hand-computed checksum 0x20.
    clearLog();
    pulseStart(1'b1);
    frame_q = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    foreach (frame_q[i]) sendByte(frame_q[i], int'($urandom_range(0, 3)));
    sendByte(8'h20, 0);
    checkOutput("t1_stall_fall", 64'(cpu_stall), 0);
    checkOutput("t1_done", 64'(load_done), 1);
    tick();
    checkOutput("t1_wc", 64'(word_count), 2);
    checkOutput("t1_nwrites", 64'(log_addr.size()), 2);
    if (log_addr.size() == 2) begin
      checkOutput("t1_addr0", 64'(log_addr[0]), 0);
      checkOutput("t1_data0", 64'(log_data[0]), 64'h DEADBEEF);
      checkOutput("t1_addr1", 64'(log_addr[1]), 1);
      checkOutput("t1_data1", 64'(log_data[1]), 64'h01234567);
    end

    // Same frame with a corrupted checksum (0x21).
    pulseStart(1'b1);
    foreach (frame_q[i]) sendByte(frame_q[i], 0);
    sendByte(8'h21, 0);
    repeat (3) tick();
    checkOutput("t2_chk_err", 64'(chk_err), 1);
    checkOutput("t2_stall", 64'(cpu_stall), 1);
    checkOutput("t2_done", 64'(load_done), 0);

    // Inter-byte timeout after two bytes of a one-word frame.
    clearLog();
    pulseStart(1'b1);
    sendByte(8'h01, 0); sendByte(8'hAA, 0); sendByte(8'hBB, 0);
    repeat (T + 10) tick();
    checkOutput("t3_timeout", 64'(timeout_err), 1);
    checkOutput("t3_wc", 64'(word_count), 0);
    checkOutput("t3_nwrites", 64'(log_addr.size()), 0);
    checkOutput("t3_stall", 64'(cpu_stall), 1);

    // Restart mid-word; only the second frame's word (checksum 0x31) is written.
    clearLog();
    pulseStart(1'b1);
    sendByte(8'h01, 0); sendByte(8'h11, 1); sendByte(8'h22, 0);
    pulseStart(1'b1);
    frame_q = '{8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    foreach (frame_q[i]) sendByte(frame_q[i], int'($urandom_range(0, 2)));
    sendByte(8'h31, 0);
    tick();
    checkOutput("t4_done", 64'(load_done), 1);
    checkOutput("t4_nwrites", 64'(log_addr.size()), 1);
    if (log_addr.size() == 1) begin
      checkOutput("t4_addr", 64'(log_addr[0]), 0);
      checkOutput("t4_data", 64'(log_data[0]), 64'hCAFEBABE);
    end

    // Full-depth image: length byte 0, word i holds value i.
    clearLog();
    pulseStart(1'b1);
    frame_q.delete();
    frame_q.push_back(8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      frame_q.push_back(8'h00); frame_q.push_back(8'h00); frame_q.push_back(8'h00);
      frame_q.push_back(8'(i));
    end
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("t5_done", 64'(load_done), 1);
    checkOutput("t5_wc", 64'(word_count), DEPTH);
    checkOutput("t5_nwrites", 64'(log_addr.size()), DEPTH);
    if (log_addr.size() == DEPTH) begin
      for (int i = 0; i < DEPTH; i++) begin
        checkOutput("t5_addr", 64'(log_addr[i]), 64'(i));
        checkOutput("t5_data", 64'(log_data[i]), 64'(i));
      end
    end

    // start without load_en leaves the finished load untouched.
    pulseStart(1'b0);
    tick();
    checkOutput("e1_busy", 64'(busy), 0);
    checkOutput("e1_done", 64'(load_done), 1);
    checkOutput("e1_wc", 64'(word_count), DEPTH);

    // Reset while the frame is in its third byte lane.
    pulseStart(1'b1);
    sendByte(8'h01, 0); sendByte(8'hAA, 0); sendByte(8'hBB, 0);
    reset = 1'b1;
    tick();
    checkOutput("e2_we", 64'(mem_we), 0);
    checkOutput("e2_waddr", 64'(mem_waddr), 0);
    checkOutput("e2_wdata", 64'(mem_wdata), 0);
    checkOutput("e2_busy", 64'(busy), 0);
    checkOutput("e2_stall", 64'(cpu_stall), 0);
    checkOutput("e2_flags", 64'({load_done, timeout_err, chk_err}), 0);
    checkOutput("e2_wc", 64'(word_count), 0);
    reset = 1'b0;
    tick();

    // Bytes arriving while idle are ignored.
    clearLog();
    for (int i = 0; i < 6; i++) sendByte(8'(i + 1), 0);
    tick();
    checkOutput("e3_nwrites", 64'(log_addr.size()), 0);
    checkOutput("e3_busy", 64'(busy), 0);

    // Randomized frames checked purely by the model, including boundary gaps of T and T+1.
    for (int f = 0; f < 25; f++) begin
      int nw;
      pulseStart($urandom_range(0, 5) != 0);
      nw = int'($urandom_range(1, 5));
      frame_q.delete();
      frame_q.push_back(8'(nw));
      for (int i = 0; i < 4 * nw; i++) frame_q.push_back(8'($urandom));
      applyStimulus($urandom_range(0, 3) == 0, 1'b1);
      repeat (int'($urandom_range(0, 4))) tick();
    end

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
